// File: rtl/uart_rx_program_loader.sv
// uart_rx_program_loader: assembles UART RX bytes into instruction words and
// writes them sequentially into program memory starting at address 0.
// A START_CMD byte opens a load session. A word carrying HALT_OPCODE closes it
// and raises o_run to release the CPU.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, one XOR checksum
// byte must follow the HALT word before o_run is raised.
module uart_rx_program_loader #(
    parameter int                            CANT_BITS_OPCODE   = 5,
    parameter int                            PC_LENGTH          = 11,
    parameter int                            INSTRUCTION_LENGTH = 16,
    parameter int                            INPUT_WORD_LENGTH  = 8,
    parameter logic [CANT_BITS_OPCODE-1:0]   HALT_OPCODE        = '0,
    parameter logic [INPUT_WORD_LENGTH-1:0]  START_CMD          = 8'hA5
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_rx_done,
    input  logic [INPUT_WORD_LENGTH-1:0]  i_data_rx,
    output logic                          o_wr_enable,
    output logic [PC_LENGTH-1:0]          o_wr_addr,
    output logic [INSTRUCTION_LENGTH-1:0] o_wr_data,
    output logic                          o_run,
    output logic                          o_error
);

    // One-hot state encoding. CHECK exists only when the checksum is built in.
    typedef enum logic [5:0] {
        ESPERA  = 6'b000001,
        RX_LOW  = 6'b000010,
        RX_HIGH = 6'b000100,
        WRITE   = 6'b001000,
`ifdef LOADER_CHECKSUM_EN
        CHECK   = 6'b010000,
`endif
        RUN     = 6'b100000
    } state_t;

    state_t                          state_q, state_d;
    logic                            rx_done_q;
    logic [INPUT_WORD_LENGTH-1:0]    low_q, low_d;
    logic [PC_LENGTH-1:0]            counter_q, counter_d;
    logic                            wr_en_q, wr_en_d;
    logic [PC_LENGTH-1:0]            wr_addr_q, wr_addr_d;
    logic [INSTRUCTION_LENGTH-1:0]   wr_data_q, wr_data_d;
    logic                            run_q, run_d;
    logic                            error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [INPUT_WORD_LENGTH-1:0]    chk_q, chk_d;
`endif

    // A byte event is the rising edge of the RX valid level. A held level counts once.
    logic byte_event;
    assign byte_event = i_rx_done && !rx_done_q;

    logic is_halt;
    assign is_halt = (wr_data_q[INSTRUCTION_LENGTH-1 -: CANT_BITS_OPCODE] == HALT_OPCODE);

    // Next-state and output logic for the load FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case. A path that skips an
        // assignment would otherwise infer a latch.
        state_d   = state_q;
        low_d     = low_q;
        counter_d = counter_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        run_d     = run_q;
        error_d   = error_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d     = chk_q;
`endif

        case (state_q)
            ESPERA: begin
                if (byte_event && i_data_rx == START_CMD) begin
                    state_d   = RX_LOW;
                    counter_d = '0;
                    error_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d     = '0;
`endif
                end
            end

            RX_LOW: begin
                if (byte_event) begin
                    low_d   = i_data_rx;
                    state_d = RX_HIGH;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ i_data_rx;
`endif
                end
            end

            RX_HIGH: begin
                if (byte_event) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = counter_q;
                    wr_data_d = {i_data_rx, low_q};
                    state_d   = WRITE;
`ifdef LOADER_CHECKSUM_EN
                    chk_d     = chk_q ^ i_data_rx;
`endif
                end
            end

            WRITE: begin
                if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = RUN;
                    run_d   = 1'b1;
`endif
                end else if (counter_q == '1) begin
                    // Memory is full. The address never wraps, so the load fails.
                    error_d = 1'b1;
                    state_d = ESPERA;
                end else begin
                    counter_d = counter_q + PC_LENGTH'(1);
                    if (byte_event) begin
                        // A byte that arrives in the strobe cycle is the next low byte.
                        low_d   = i_data_rx;
                        state_d = RX_HIGH;
`ifdef LOADER_CHECKSUM_EN
                        chk_d   = chk_q ^ i_data_rx;
`endif
                    end else begin
                        state_d = RX_LOW;
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (byte_event) begin
                    if (i_data_rx == chk_q) begin
                        state_d = RUN;
                        run_d   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        state_d = ESPERA;
                    end
                end
            end
`endif

            RUN: begin
                if (byte_event && i_data_rx == START_CMD) begin
                    run_d     = 1'b0;
                    state_d   = RX_LOW;
                    counter_d = '0;
                    error_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d     = '0;
`endif
                end
            end

            default: state_d = ESPERA;
        endcase
    end

    // State and output registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ESPERA;
            rx_done_q <= 1'b0;
            low_q     <= '0;
            counter_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            run_q     <= 1'b0;
            error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments here, so every register samples the
            // pre-edge values no matter what order the statements are in.
            state_q   <= state_d;
            rx_done_q <= i_rx_done;
            low_q     <= low_d;
            counter_q <= counter_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            run_q     <= run_d;
            error_q   <= error_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    assign o_wr_enable = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_run       = run_q;
    assign o_error     = error_q;

endmodule

// File: doc/uart_rx_program_loader.md
# uart_rx_program_loader

Receive-side companion of the CPU's UART output interface: takes bytes delivered by the UART receiver, assembles them into instruction words and writes them sequentially into program memory starting at address 0. Loading starts on a command byte and ends when an instruction with the HALT opcode has been written; the block then raises a run enable that releases the CPU. It sits between the UART RX core and the program memory / CPU enable.

## Interface
- CANT_BITS_OPCODE, 5, opcode width; opcode = top CANT_BITS_OPCODE bits of an instruction word
- PC_LENGTH, 11, program memory address width
- INSTRUCTION_LENGTH, 16, instruction word width (exactly two bytes)
- INPUT_WORD_LENGTH, 8, UART byte width
- HALT_OPCODE, 0, opcode that terminates loading
- START_CMD, 8'hA5, byte that opens a load session
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_done  in  1  UART RX byte-valid level; a byte event is its rising edge
- i_data_rx  in  INPUT_WORD_LENGTH  received byte, valid while i_rx_done high
- o_wr_enable  out  1  program memory write strobe, one cycle per word
- o_wr_addr  out  PC_LENGTH  write address
- o_wr_data  out  INSTRUCTION_LENGTH  write data
- o_run  out  1  CPU run enable, level
- o_error  out  1  load failed (overflow or checksum), sticky until next START_CMD

## Operation
- Byte event: i_rx_done==1 and registered previous i_rx_done==0; held-high i_rx_done yields one event. i_data_rx sampled on the event cycle.
- States (one-hot): ESPERA, RX_LOW, RX_HIGH, WRITE, CHECK (macro only), RUN.
- ESPERA: event with byte==START_CMD -> RX_LOW, address counter=0, o_error=0, checksum=0; other bytes ignored.
- RX_LOW: event -> store byte as bits [7:0] -> RX_HIGH.
- RX_HIGH: event -> store byte as bits [15:8] -> WRITE.
- WRITE: o_wr_enable=1 for this single cycle with o_wr_addr=counter, o_wr_data=assembled word. Next:
  - opcode==HALT_OPCODE -> RUN (or CHECK with macro);
  - else counter==2^PC_LENGTH-1 -> o_error=1, ESPERA (no wrap);
  - else counter+1, -> RX_LOW.
- RUN: o_run=1. Event with START_CMD -> o_run=0, restart as from ESPERA; other bytes ignored.
- Byte event in WRITE cycle: processed as in RX_LOW (stored as low byte, next state RX_HIGH instead of RX_LOW).
- Undefined state -> ESPERA.

## Timing
- Reset (async, any time, including mid-load): state ESPERA, o_wr_enable=0, o_wr_addr=0, o_wr_data=0, o_run=0, o_error=0, edge register=0, counter=0.
- All outputs registered. High-byte event sampled at edge N -> o_wr_enable high during cycle N..N+1 (one cycle), o_wr_addr/o_wr_data stable that cycle and held afterwards.
- HALT word: o_run rises the cycle after its write strobe (no macro).
- START_CMD in RUN: o_run low the cycle after the event.
- o_error rises the cycle after the failing write/check, held until next accepted START_CMD.

## Configuration
- LOADER_CHECKSUM_EN defined: running XOR of all instruction bytes (START_CMD excluded). After HALT write -> CHECK; next byte event compared: equal -> RUN; different -> o_error=1, ESPERA, o_run stays 0.
- Undefined: no CHECK state, no checksum register; HALT write -> RUN directly.

## Test plan
- Basic load: A5, 34, 12, 00, 00 -> writes addr0=0x1234, addr1=0x0000; o_run=1 cycle after second strobe; exactly two strobes.
- Pre-start noise: 12, 77, A5, 00, 00 -> only one write (addr0=0x0000), o_run=1; bytes before A5 produce no strobe.
- Held i_rx_done: each byte held high 20 cycles -> one event per byte, same writes as basic load.
- Overflow (PC_LENGTH=2): A5 then four words 0x0801 -> four strobes addr 0..3, o_error=1, o_run=0, state ESPERA; then A5,00,00 -> o_error=0, o_run=1.
- Reset mid-load: A5, 34, 12, 34, assert i_reset -> all outputs 0 immediately, no further strobe; A5, 00, 00 -> write at addr0.
- With LOADER_CHECKSUM_EN: A5, 34, 12, 00, 00, 26 -> o_run=1; same with final 27 -> o_error=1, o_run=0.
